// File: rtl/peripheral_sync_event_pkg.sv
// Shared types and helpers for the peripheral sync event arbiter.
//   state_t  : arbiter FSM states
//   MAX_SRC  : upper limit on the number of event sources
//   rr_pick  : round-robin winner search over a pending vector
package peripheral_sync_event_pkg;

  localparam int unsigned MAX_SRC  = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Search starts one past the last grant and wraps modulo n; first pending wins.
  // Callers guarantee last < n and 2 <= n <= MAX_SRC.
  function automatic logic [MAX_ID_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0]  pend,
    input logic [MAX_ID_W-1:0] last,
    input int unsigned         n
  );
    logic [MAX_ID_W-1:0] win;
    logic                found;
    logic [MAX_ID_W:0]   idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      idx = (MAX_ID_W+1)'(last) + (MAX_ID_W+1)'(k);
      // last < n and k <= n, so a single subtraction completes the wrap
      if (idx >= (MAX_ID_W+1)'(n)) idx = idx - (MAX_ID_W+1)'(n);
      if (!found && (k <= n) && pend[idx[MAX_ID_W-1:0]]) begin
        win   = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/peripheral_sync_cell.sv
// Two-flop synchronizer for one asynchronous line into the clk domain.
//   clk, rst : receiving clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronized level
module peripheral_sync_cell (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/peripheral_sync_event_arbiter.sv
// Synchronizes NUM_SRC asynchronous event lines, latches their rising edges as
// pending events and delivers them one at a time, round-robin, over valid/ready.
//   clk, rst          : clock, async active-high reset
//   async_in, src_en  : raw event lines, per-source enables
//   evt_valid, evt_id : offered event and its source index
//   evt_ready         : consumer accepts the offered event
//   pending, overflow : latched events, sticky lost-edge flags
//   ovf_clr           : write-1-to-clear for overflow
//   level_out         : synchronized level of each line
// NUM_SRC legal range is 2..MAX_SRC.
module peripheral_sync_event_arbiter
  import peripheral_sync_event_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] async_in,
  input  logic [NUM_SRC-1:0] src_en,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overflow,
  input  logic [NUM_SRC-1:0] ovf_clr,
  output logic [NUM_SRC-1:0] level_out
);

  state_t             state_q, state_d;
  logic               evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] overflow_q, overflow_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] offer_sel;
  logic [NUM_SRC-1:0] acc_sel;
  logic               accept;

  // One synchronizer per line
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    peripheral_sync_cell u_sync (
      .clk (clk),
      .rst (rst),
      .d   (async_in[g]),
      .q   (level_out[g])
    );
  end

  // Edge detect and handshake decode
  always_comb begin
    prev_d    = level_out;
    rise      = level_out & ~prev_q & src_en;
    accept    = evt_valid_q & evt_ready;
    offer_sel = '0;
    offer_sel[evt_id_q] = evt_valid_q;
    acc_sel   = offer_sel & {NUM_SRC{evt_ready}};
  end

  // Pending / overflow update; a set of overflow beats a same-cycle clear
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q & ~ovf_clr;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!src_en[i] && !offer_sel[i]) begin
        pending_d[i] = 1'b0;
      end else if (rise[i] && acc_sel[i]) begin
        // new edge arrives as the old one is delivered: keep it, no loss
        pending_d[i] = 1'b1;
      end else if (rise[i]) begin
        pending_d[i] = 1'b1;
        if (pending_q[i]) overflow_d[i] = 1'b1;
      end else if (acc_sel[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Arbiter FSM next state; an offer is only withdrawn by an accept
  always_comb begin
    state_d      = state_q;
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          evt_id_d    = ID_W'(rr_pick(MAX_SRC'(pending_q), MAX_ID_W'(last_grant_q), NUM_SRC));
          evt_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          evt_valid_d  = 1'b0;
          last_grant_d = evt_id_q;
          state_d      = IDLE;
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      pending_q    <= '0;
      overflow_q   <= '0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      prev_q       <= prev_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
